// File: rtl/i2c_bus_scheduler_if.sv
// Bus bundle between sensor requesters, the scheduler and one i2c_master.
// The slave modport is the scheduler's view; master is the requester/i2c side.
interface i2c_bus_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic                   enable;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*7-1:0]   req_addr;
    logic [NUM_REQ-1:0]     req_rw_n;
    logic [NUM_REQ*8-1:0]   req_wdata;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     done;
    logic [NUM_REQ-1:0]     err;
    logic [7:0]             rdata;
    logic                   m_start;
    logic [6:0]             m_addr;
    logic                   m_rw_n;
    logic [7:0]             m_wdata;
    logic [7:0]             m_rdata;
    logic                   m_done;
    logic                   m_ack_error;
    logic                   busy;
    logic                   timeout_err;

    modport slave (
        input  enable, req, req_addr, req_rw_n, req_wdata, m_rdata, m_done, m_ack_error,
        output gnt, done, err, rdata, m_start, m_addr, m_rw_n, m_wdata, busy, timeout_err
    );

    modport master (
        output enable, req, req_addr, req_rw_n, req_wdata, m_rdata, m_done, m_ack_error,
        input  gnt, done, err, rdata, m_start, m_addr, m_rw_n, m_wdata, busy, timeout_err
    );
endinterface

// File: rtl/i2c_bus_scheduler.sv
// Round-robin scheduler sharing one i2c_master among NUM_REQ sensor requesters.
// Each transaction: grant, one-cycle start, wait for completion or timeout,
// one-cycle response pulse to the owner, then an enforced idle gap.
module i2c_bus_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic              clk,
    input  logic              rst,
    i2c_bus_scheduler_if.slave bus
);
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, GAP} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx;
    logic               found;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] gnt_r;
    logic [7:0]         rdata_r;
    logic [6:0]         addr_r;
    logic               rw_n_r;
    logic [7:0]         wdata_r;
    logic               resp_err;
    logic               resp_to;
    logic               grant_now;
    logic               wait_resp;
    logic               wait_to;
    logic               gap_last;

    // Round-robin search starting at rr_ptr; first active request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state decode; master completion wins over a same-cycle timeout.
    always_comb begin
        grant_now = (state == IDLE) && bus.enable && found;
        wait_resp = (state == WAIT) && (bus.m_done || bus.m_ack_error);
        wait_to   = (state == WAIT) && !wait_resp && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        gap_last  = (state == GAP) && (cnt == CNT_W'(GAP_CYCLES - 1));
        state_nxt = state;
        case (state)
            IDLE:    if (grant_now) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (wait_resp || wait_to) state_nxt = RESP;
            RESP:    state_nxt = GAP;
            GAP:     if (gap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Shared timeout/gap counter, cleared on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  cnt <= '0;
        else if (state != state_nxt)              cnt <= '0;
        else if (state == WAIT || state == GAP)   cnt <= cnt + 1'b1;
    end

    // Grant and request latch; the latched command stays frozen until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_r   <= '0;
            rr_ptr  <= '0;
            addr_r  <= '0;
            rw_n_r  <= 1'b0;
            wdata_r <= '0;
        end else if (grant_now) begin
            gnt_r   <= NUM_REQ'(1) << winner;
            rr_ptr  <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            addr_r  <= bus.req_addr[int'(winner)*7 +: 7];
            rw_n_r  <= bus.req_rw_n[winner];
            wdata_r <= bus.req_wdata[int'(winner)*8 +: 8];
        end else if (state == RESP) begin
            gnt_r   <= '0;
        end
    end

    // Completion capture; read data only updates on a clean read completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err <= 1'b0;
            resp_to  <= 1'b0;
            rdata_r  <= '0;
        end else if (wait_resp || wait_to) begin
            resp_err <= bus.m_ack_error || wait_to;
            resp_to  <= wait_to;
            if (bus.m_done && !bus.m_ack_error && rw_n_r) rdata_r <= bus.m_rdata;
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.done        = (state == RESP) ? gnt_r : '0;
    assign bus.err         = (state == RESP && resp_err) ? gnt_r : '0;
    assign bus.timeout_err = (state == RESP) && resp_to;
    assign bus.rdata       = rdata_r;
    assign bus.m_start     = (state == START);
    assign bus.m_addr      = addr_r;
    assign bus.m_rw_n      = rw_n_r;
    assign bus.m_wdata     = wdata_r;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Directed bench for i2c_bus_scheduler with a hand-driven i2c_master model.
module tb_i2c_bus_scheduler;
    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 40;
    localparam int GAP_CYCLES     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    i2c_bus_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();

    i2c_bus_scheduler #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.m_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic set_fields(input int i, input logic [6:0] a, input logic rw, input logic [7:0] d);
        bus.req_addr[i*7 +: 7]  = a;
        bus.req_rw_n[i]         = rw;
        bus.req_wdata[i*8 +: 8] = d;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        checks++; if ({bus.done, bus.err} !== 8'h00) begin errors++; $display("FAIL reset_done_err: got %b want 0", {bus.done, bus.err}); end
        checks++; if ({bus.m_start, bus.busy, bus.timeout_err, bus.m_rw_n} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {bus.m_start, bus.busy, bus.timeout_err, bus.m_rw_n}); end
        checks++; if ({bus.rdata, bus.m_addr, bus.m_wdata} !== 23'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {bus.rdata, bus.m_addr, bus.m_wdata}); end
        rst = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single_read();
        set_fields(0, 7'h48, 1'b1, 8'h00);
        bus.req = 4'b0001;
        step();
        checks++; if (bus.m_start !== 1'b1) begin errors++; $display("FAIL read_start_latency: got %b want 1", bus.m_start); end
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL read_gnt: got %b want 0001", bus.gnt); end
        checks++; if (bus.m_addr !== 7'h48 || bus.m_rw_n !== 1'b1) begin errors++; $display("FAIL read_cmd: got addr %h rw %b want 48 1", bus.m_addr, bus.m_rw_n); end
        step();
        checks++; if (bus.m_start !== 1'b0) begin errors++; $display("FAIL read_start_width: got %b want 0", bus.m_start); end
        repeat (9) step();
        bus.m_rdata = 8'hA5;
        bus.m_done  = 1'b1;
        step();
        checks++; if (bus.done !== 4'b0001 || bus.err !== 4'b0000) begin errors++; $display("FAIL read_done: got done %b err %b want 0001 0000", bus.done, bus.err); end
        checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h want a5", bus.rdata); end
        bus.m_done = 1'b0;
        bus.req    = 4'b0000;
        step();
        checks++; if (bus.done !== 4'b0000 || bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL read_gap_entry: got done %b gnt %b busy %b want 0000 0000 1", bus.done, bus.gnt, bus.busy); end
        repeat (GAP_CYCLES - 1) step();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL read_gap_last: got busy %b want 1", bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0 || bus.rdata !== 8'hA5) begin errors++; $display("FAIL read_gap_end: got busy %b rdata %h want 0 a5", bus.busy, bus.rdata); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int k;
        logic [3:0] exp_gnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_fields(i, 7'(8'h10 + i), 1'b0, 8'(i));
        bus.req = 4'b1111;
        k = 0;
        for (int n = 0; n < 5; n++) begin
            exp_gnt = 4'b0001 << (n % 4);
            wait_start(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_start_timeout: got no m_start want m_start for grant %0d", n); end
            if (n > 0) begin
                checks++; if (k !== 8) begin errors++; $display("FAIL rr_spacing: got %0d cycles want 8 between starts", k); end
            end
            checks++; if (bus.gnt !== exp_gnt) begin errors++; $display("FAIL rr_order: got %b want %b at grant %0d", bus.gnt, exp_gnt, n); end
            checks++; if (bus.m_addr !== 7'(8'h10 + (n % 4))) begin errors++; $display("FAIL rr_addr: got %h want %h", bus.m_addr, 8'h10 + (n % 4)); end
            bus.m_done = 1'b1;
            step();
            step();
            bus.m_done = 1'b0;
            checks++; if (bus.done !== exp_gnt) begin errors++; $display("FAIL rr_done: got %b want %b", bus.done, exp_gnt); end
            if (n < 4) begin
                k = 2;
                while (!bus.m_start && k < 60) begin
                    step();
                    k++;
                end
            end
        end
        bus.req = 4'b0000;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_idle_timeout: got busy want idle"); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit early;
        set_fields(1, 7'h22, 1'b1, 8'h00);
        bus.req = 4'b0010;
        wait_start(ok);
        checks++; if (!ok || bus.gnt !== 4'b0010) begin errors++; $display("FAIL to_grant: got ok %b gnt %b want 1 0010", ok, bus.gnt); end
        early = 1'b0;
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            step();
            if (bus.done != 4'b0000 || bus.timeout_err) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL to_early: got early response %b want 0", early); end
        step();
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", bus.timeout_err); end
        checks++; if (bus.done !== 4'b0010 || bus.err !== 4'b0010) begin errors++; $display("FAIL to_done_err: got done %b err %b want 0010 0010", bus.done, bus.err); end
        step();
        checks++; if (bus.timeout_err !== 1'b0 || bus.err !== 4'b0000) begin errors++; $display("FAIL to_pulse_width: got to %b err %b want 0 0000", bus.timeout_err, bus.err); end
        // completion in the very cycle the timeout would expire
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_race_start: got no m_start want m_start"); end
        repeat (TIMEOUT_CYCLES) step();
        bus.m_rdata = 8'h5A;
        bus.m_done  = 1'b1;
        step();
        bus.m_done = 1'b0;
        bus.req    = 4'b0000;
        checks++; if (bus.done !== 4'b0010 || bus.err !== 4'b0000 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_race: got done %b err %b to %b want 0010 0000 0", bus.done, bus.err, bus.timeout_err); end
        checks++; if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL to_race_rdata: got %h want 5a", bus.rdata); end
        wait_idle(ok);
    endtask

    task automatic test_ack_error();
        bit ok;
        set_fields(2, 7'h33, 1'b0, 8'h3C);
        bus.req = 4'b0100;
        wait_start(ok);
        checks++; if (!ok || bus.gnt !== 4'b0100) begin errors++; $display("FAIL ack_grant: got ok %b gnt %b want 1 0100", ok, bus.gnt); end
        checks++; if (bus.m_wdata !== 8'h3C || bus.m_rw_n !== 1'b0) begin errors++; $display("FAIL ack_cmd: got wdata %h rw %b want 3c 0", bus.m_wdata, bus.m_rw_n); end
        repeat (5) step();
        set_fields(2, 7'h7F, 1'b1, 8'hFF);
        bus.m_ack_error = 1'b1;
        #1;
        checks++; if (bus.m_wdata !== 8'h3C || bus.m_addr !== 7'h33 || bus.m_rw_n !== 1'b0) begin errors++; $display("FAIL ack_latch_stable: got %h %h %b want 3c 33 0", bus.m_wdata, bus.m_addr, bus.m_rw_n); end
        step();
        bus.m_ack_error = 1'b0;
        checks++; if (bus.err !== 4'b0100 || bus.done !== 4'b0100 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL ack_err: got err %b done %b to %b want 0100 0100 0", bus.err, bus.done, bus.timeout_err); end
        checks++; if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL ack_rdata: got %h want 5a", bus.rdata); end
        // done and ack error together on a read
        wait_start(ok);
        checks++; if (!ok || bus.m_rw_n !== 1'b1) begin errors++; $display("FAIL both_start: got ok %b rw %b want 1 1", ok, bus.m_rw_n); end
        step();
        bus.m_rdata     = 8'h77;
        bus.m_done      = 1'b1;
        bus.m_ack_error = 1'b1;
        step();
        bus.m_done      = 1'b0;
        bus.m_ack_error = 1'b0;
        bus.req         = 4'b0000;
        checks++; if (bus.err !== 4'b0100 || bus.done !== 4'b0100) begin errors++; $display("FAIL both_err: got err %b done %b want 0100 0100", bus.err, bus.done); end
        checks++; if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL both_rdata: got %h want 5a", bus.rdata); end
        wait_idle(ok);
    endtask

    task automatic test_enable();
        bit ok;
        bit seen;
        set_fields(0, 7'h48, 1'b0, 8'h11);
        bus.enable = 1'b0;
        bus.req    = 4'b0001;
        bus.m_done = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            step();
            if (bus.gnt != 4'b0000 || bus.m_start || bus.busy || bus.done != 4'b0000) seen = 1'b1;
        end
        bus.m_done = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL en_block: got activity %b want 0", seen); end
        bus.enable = 1'b1;
        step();
        checks++; if (bus.gnt !== 4'b0001 || bus.m_start !== 1'b1) begin errors++; $display("FAIL en_grant: got gnt %b start %b want 0001 1", bus.gnt, bus.m_start); end
        step();
        bus.enable = 1'b0;
        repeat (3) step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        bus.req    = 4'b0000;
        checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL en_drop_done: got %b want 0001", bus.done); end
        bus.enable = 1'b1;
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_fields(3, 7'h44, 1'b0, 8'h99);
        bus.req = 4'b1000;
        wait_start(ok);
        step();
        step();
        rst = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.m_start !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got gnt %b busy %b start %b want 0000 0 0", bus.gnt, bus.busy, bus.m_start); end
        checks++; if (bus.rdata !== 8'h00 || bus.m_addr !== 7'h00 || bus.m_wdata !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h %h %h want 0 0 0", bus.rdata, bus.m_addr, bus.m_wdata); end
        step();
        checks++; if (bus.done !== 4'b0000 || bus.err !== 4'b0000) begin errors++; $display("FAIL rst_mid_done: got done %b err %b want 0000 0000", bus.done, bus.err); end
        rst = 1'b0;
        step();
        checks++; if (bus.gnt !== 4'b1000 || bus.m_start !== 1'b1) begin errors++; $display("FAIL rst_regrant: got gnt %b start %b want 1000 1", bus.gnt, bus.m_start); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        bus.req    = 4'b0000;
        checks++; if (bus.done !== 4'b1000) begin errors++; $display("FAIL rst_regrant_done: got %b want 1000", bus.done); end
        wait_idle(ok);
        // pointer must return to zero: lowest active index wins after reset
        set_fields(2, 7'h33, 1'b0, 8'h00);
        bus.req = 4'b0100;
        wait_start(ok);
        step();
        rst = 1'b1;
        bus.req = 4'b1010;
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rst_lowest: got %b want 0010", bus.gnt); end
        step();
        bus.m_done = 1'b1;
        step();
        bus.m_done = 1'b0;
        bus.req    = 4'b0000;
        checks++; if (bus.done !== 4'b0010) begin errors++; $display("FAIL rst_lowest_done: got %b want 0010", bus.done); end
        wait_idle(ok);
    endtask

    initial begin
        bus.enable      = 1'b1;
        bus.req         = '0;
        bus.req_addr    = '0;
        bus.req_rw_n    = '0;
        bus.req_wdata   = '0;
        bus.m_rdata     = '0;
        bus.m_done      = 1'b0;
        bus.m_ack_error = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_ack_error();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_bus_scheduler.md
I2C_BUS_SCHEDULER -- requirements
Module: i2c_bus_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of sensor requesters sharing one i2c_master.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20000, max cycles waited for master completion.
REQ-003 SHALL have parameter GAP_CYCLES, default 4, bus-idle cycles enforced between transactions (min 1).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 enable  input  1  low blocks new grants; an in-flight transaction completes.
REQ-008 req  input  NUM_REQ  per-requester transaction request, level, held until done.
REQ-009 req_addr  input  NUM_REQ*7  per-requester 7-bit slave address, slice i = [7i+6:7i].
REQ-010 req_rw_n  input  NUM_REQ  per-requester direction, 1 = read.
REQ-011 req_wdata  input  NUM_REQ*8  per-requester write byte, slice i = [8i+7:8i].
REQ-012 gnt  output  NUM_REQ  one-hot grant, high while requester owns the bus.
REQ-013 done  output  NUM_REQ  one-cycle completion pulse to owner.
REQ-014 err  output  NUM_REQ  one-cycle error pulse, coincident with done.
REQ-015 rdata  output  8  last read byte, valid from done pulse until next read completes.
REQ-016 m_start, m_addr[6:0], m_rw_n, m_wdata[7:0]  outputs  to i2c_master start_transaction/slave_addr/read_write_n/write_data.
REQ-017 m_rdata[7:0], m_done, m_ack_error  inputs  from i2c_master read_data/transaction_done/ack_error.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 timeout_err  output  1  one-cycle pulse when a transaction times out.

Function
REQ-020 SHALL implement FSM states IDLE, START, WAIT, RESP, GAP.
REQ-021 IDLE: if enable and any req bit high, SHALL select winner by round-robin from rr_ptr upward (wrapping at NUM_REQ), latch its addr/rw_n/wdata into m_addr/m_rw_n/m_wdata, set gnt[winner], go START next edge.
REQ-022 rr_ptr SHALL update to (winner+1) mod NUM_REQ on every grant.
REQ-023 START: m_start SHALL be high for exactly this one cycle; next state WAIT; timeout counter cleared.
REQ-024 WAIT: counter SHALL increment each cycle; on m_done or m_ack_error go RESP; on counter reaching TIMEOUT_CYCLES-1 without either, go RESP flagged as timeout.
REQ-025 WAIT with m_done and read: rdata SHALL capture m_rdata on that edge.
REQ-026 m_done and m_ack_error same cycle SHALL be treated as error, rdata not updated.
REQ-027 m_done/m_ack_error in the same cycle as timeout expiry SHALL win; no timeout reported.
REQ-028 RESP: done[owner] SHALL pulse one cycle; err[owner] pulses if ack error or timeout; timeout_err pulses on timeout; gnt cleared at exit; next state GAP.
REQ-029 GAP: SHALL hold GAP_CYCLES cycles with no grant, then IDLE.
REQ-030 m_done/m_ack_error outside WAIT SHALL be ignored.
REQ-031 Requester deasserting req mid-transaction SHALL NOT abort it; done/err still issued.
REQ-032 Latched m_addr/m_rw_n/m_wdata SHALL stay stable from START through RESP regardless of req_* changes.
REQ-033 Minimum cycle from req high in IDLE to m_start high SHALL be 1 cycle (START state).
REQ-034 At most one gnt/done/err bit SHALL be high in any cycle.
REQ-035 enable low SHALL only affect IDLE arbitration; other states proceed unchanged.

Reset
REQ-036 On rst high SHALL asynchronously force state IDLE, rr_ptr 0, counters 0, and gnt, done, err, rdata, m_start, m_addr, m_rw_n, m_wdata, busy, timeout_err all 0.
REQ-037 Reset mid-transaction SHALL abandon it with no done/err pulse; first grant after release goes to lowest-index active req.

Verification
REQ-038 req=4'b0001, addr0=7'h48, read, master returns m_rdata=8'hA5 with m_done 10 cycles after m_start -> m_start one cycle, m_addr=7'h48, done[0] pulse, err[0]=0, rdata=8'hA5.
REQ-039 req=4'b1111 held, master always completes -> grants in order 0,1,2,3,0 with >=GAP_CYCLES idle between m_start windows.
REQ-040 req=4'b0010, master never responds -> done[1] and err[1] pulse and timeout_err pulses exactly TIMEOUT_CYCLES cycles after START exit.
REQ-041 req=4'b0100 write 8'h3C, m_ack_error at cycle 5 -> err[2]+done[2] pulse, rdata unchanged; m_done and m_ack_error together -> err asserted.
REQ-042 rst asserted during WAIT with req=4'b1000 -> all outputs 0 immediately, no done; after release gnt[3] granted next cycle.
REQ-043 enable=0 with req=4'b0001 -> no gnt; enable dropped during WAIT -> transaction completes with done[0].
